input_buffer_loader: RTL and testbench
======================================

Name: input_buffer_loader

Overview:
- Upstream neighbour of the 128-bit input buffer RAM.
- Accepts a valid/ready stream of 16-bit sensor samples for one frame and packs them into 128-bit words.
- Writes each packed word into the buffer through its chip-select / write-enable port, at consecutive addresses from a programmable base.
- Reports frame completion, the number of words written, and a sticky overflow error.

Parameters:
- DATA_WIDTH, 128, buffer word width; must be an integer multiple of SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16, width of one input sample.
- ADDR_WIDTH, 8, buffer address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- LANES, DATA_WIDTH/SAMPLE_WIDTH (8), samples per word. Derived; never overridden.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- start_addr  input  ADDR_WIDTH  base buffer address; latched on an accepted start.
- in_valid  input  1  sample valid.
- in_ready  output  1  loader can accept a sample.
- in_data  input  SAMPLE_WIDTH  sample value.
- in_last  input  1  qualifies the final sample of the frame.
- buf_address  output  ADDR_WIDTH  buffer address.
- buf_data  output  DATA_WIDTH  write data; the top level drives it onto the buffer's bidirectional bus while buf_drive=1.
- buf_drive  output  1  tristate enable for buf_data; equals buf_cs & buf_we.
- buf_cs  output  1  buffer chip select.
- buf_we  output  1  buffer write enable.
- buf_oe  output  1  buffer output enable; tied 0.
- busy  output  1  state != IDLE.
- frame_done  output  1  one-cycle pulse at the end of a frame.
- word_count  output  ADDR_WIDTH+1  words written in the current or last frame.
- err_overflow  output  1  sticky; a frame exceeded the buffer top.

Behaviour:
- Reset: asynchronous and active-high. It forces:
  - state = IDLE; in_ready, buf_cs, buf_we, buf_drive, buf_oe, busy, frame_done, err_overflow = 0.
  - buf_address, buf_data, word_count, lane counter, pack register = 0.
  - Reset mid-write aborts the write; no partial word is written after reset deasserts.
- Handshake: a sample transfers on a rising clk edge where in_valid & in_ready = 1.
- IDLE:
  - in_ready = 0.
  - start = 1 → latch start_addr into the address counter; clear word_count, lane counter, pack register and err_overflow; go to PACK.
- PACK:
  - in_ready = 1.
  - An accepted sample is placed in lane k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]; k starts at 0, so the first sample occupies the LSBs.
  - Go to WRITE on the accept that fills lane LANES-1, or on any accept with in_last = 1.
  - Unfilled lanes of a partial word are zero.
- WRITE (exactly one cycle):
  - in_ready = 0; buf_cs = buf_we = buf_drive = 1; buf_address = address counter; buf_data = packed word.
  - Latency: the write is presented on the cycle after the completing sample is accepted.
  - On exit: address counter +1, word_count +1, lane counter and pack register cleared.
  - Next state: DONE if the word held the last sample, else PACK.
- Overflow:
  - A word is written at address RAM_DEPTH-1 and the frame has not ended → set err_overflow and go to DRAIN instead of PACK.
  - The address counter never wraps to 0.
- DRAIN:
  - in_ready = 1; samples are accepted and discarded; no buffer writes.
  - An accept with in_last = 1 → DONE.
- DONE: frame_done = 1 for one cycle, then IDLE. word_count and err_overflow hold until the next accepted start.
- Simultaneous events:
  - start outside IDLE is ignored.
  - in_last on the sample that fills lane LANES-1 produces a single write, then DONE.
  - in_valid outside PACK/DRAIN has no effect.
- Throughput: at most LANES samples per LANES+1 cycles.
- buf_data and buf_address hold their last values when buf_cs = 0.

Test Plan:
- 8 samples to full word: start with start_addr = 0x10, then samples 0x0001..0x0008 back-to-back (last on the 8th) → one write at 0x10 with data 0x0008_0007_0006_0005_0004_0003_0002_0001; frame_done pulses 2 cycles after the 8th accept; word_count = 1; err_overflow = 0.
- Partial word: start_addr = 0x00, samples 0xAAAA, 0xBBBB, 0xCCCC (last on 3rd) → write at 0x00 with data 0x...0000_CCCC_BBBB_AAAA (upper 80 bits zero); word_count = 1.
- Multi-word with backpressure: 20 continuous samples → writes at base, base+1, base+2 (third word holds 4 samples, rest zero); in_ready is 0 for exactly one cycle after each 8th sample and after the last; word_count = 3.
- Overflow: start_addr = 0xFF, 24 samples (last on 24th) → single write at 0xFF; no write at 0x00; err_overflow = 1; all 24 samples accepted; frame_done pulses; word_count = 1. A later start clears err_overflow.
- Reset and start collision:
  - Assert rst while 5 samples are packed → all outputs return to reset values immediately; no write follows.
  - start pulsed while busy=1 → ignored, start_addr not re-latched.

Source files
------------

// File: rtl/input_buffer_loader.sv
// Packs a stream of samples into buffer-width words and writes them to the input
// buffer RAM at consecutive addresses from a base. Reports completion, word count and overflow.
module input_buffer_loader #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SAMPLE_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic [ADDR_WIDTH-1:0]   buf_address,
    output logic [DATA_WIDTH-1:0]   buf_data,
    output logic                    buf_drive,
    output logic                    buf_cs,
    output logic                    buf_we,
    output logic                    buf_oe,
    output logic                    busy,
    output logic                    frame_done,
    output logic [ADDR_WIDTH:0]     word_count,
    output logic                    err_overflow
);

    localparam int LANES  = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PACK,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [LANE_W-1:0]       lane_cnt;
    logic [DATA_WIDTH-1:0]   pack_reg;
    logic [DATA_WIDTH-1:0]   pack_next;
    logic                    last_word;
    logic                    accept;
    logic                    lane_full;
    logic                    addr_top;

    assign accept    = in_valid & in_ready;
    assign lane_full = (lane_cnt == LANE_W'(LANES - 1));
    assign addr_top  = (addr_cnt == {ADDR_WIDTH{1'b1}});
    assign buf_oe    = 1'b0;

    // Word as it will look once the sample on the bus lands in the current lane.
    always_comb begin
        pack_next = pack_reg;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                pack_next[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            buf_cs       <= 1'b0;
            buf_we       <= 1'b0;
            buf_drive    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            buf_address  <= '0;
            buf_data     <= '0;
            word_count   <= '0;
            addr_cnt     <= '0;
            lane_cnt     <= '0;
            pack_reg     <= '0;
            last_word    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            buf_cs     <= 1'b0;
            buf_we     <= 1'b0;
            buf_drive  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_cnt     <= start_addr;
                        word_count   <= '0;
                        lane_cnt     <= '0;
                        pack_reg     <= '0;
                        err_overflow <= 1'b0;
                        last_word    <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_PACK;
                    end
                end

                S_PACK: begin
                    if (accept) begin
                        if (lane_full || in_last) begin
                            // Present the write on the very next cycle.
                            buf_cs      <= 1'b1;
                            buf_we      <= 1'b1;
                            buf_drive   <= 1'b1;
                            buf_address <= addr_cnt;
                            buf_data    <= pack_next;
                            last_word   <= in_last;
                            in_ready    <= 1'b0;
                            state       <= S_WRITE;
                        end else begin
                            pack_reg <= pack_next;
                            lane_cnt <= lane_cnt + LANE_W'(1);
                        end
                    end
                end

                S_WRITE: begin
                    word_count <= word_count + (ADDR_WIDTH+1)'(1);
                    lane_cnt   <= '0;
                    pack_reg   <= '0;
                    // The counter saturates at the buffer top rather than wrapping onto word 0.
                    if (!addr_top) begin
                        addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                    end
                    if (last_word) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else if (addr_top) begin
                        err_overflow <= 1'b1;
                        in_ready     <= 1'b1;
                        state        <= S_DRAIN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_PACK;
                    end
                end

                S_DRAIN: begin
                    if (accept && in_last) begin
                        in_ready   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer_loader.sv
// Directed bench for input_buffer_loader: a frame-level model predicts every buffer write,
// a monitor checks each write as it appears, and literal checks pin key words and timing.
module tb_input_buffer_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   start_addr;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic [7:0]   buf_address;
    logic [127:0] buf_data;
    logic         buf_drive;
    logic         buf_cs;
    logic         buf_we;
    logic         buf_oe;
    logic         busy;
    logic         frame_done;
    logic [8:0]   word_count;
    logic         err_overflow;

    input_buffer_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .buf_address  (buf_address),
        .buf_data     (buf_data),
        .buf_drive    (buf_drive),
        .buf_cs       (buf_cs),
        .buf_we       (buf_we),
        .buf_oe       (buf_oe),
        .busy         (busy),
        .frame_done   (frame_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    logic [15:0]  samp[$];
    logic [7:0]   exp_addr[$];
    logic [127:0] exp_data[$];
    logic [8:0]   exp_wc;
    logic         exp_err;
    int           stalls;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Frame model: split the samples into 8-sample words at base, base+1, ... and stop
    // writing once a word lands on the top address while samples remain.
    task automatic plan(input logic [7:0] base);
        int n;
        int nwords;
        int addr;
        logic [127:0] word;
        n      = samp.size();
        nwords = (n + 7) / 8;
        addr   = base;
        exp_wc = 9'd0;
        exp_err = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            word = '0;
            for (int l = 0; l < 8; l++)
                if (w*8 + l < n) word[l*16 +: 16] = samp[w*8 + l];
            exp_addr.push_back(8'(addr));
            exp_data.push_back(word);
            exp_wc = exp_wc + 9'd1;
            if (addr == 255 && w < nwords - 1) begin
                exp_err = 1'b1;
                break;
            end
            addr++;
        end
    endtask

    always @(negedge clk) begin
        if (buf_cs || buf_drive) begin
            check("drive_eq_cs_we", 128'(buf_drive), 128'(buf_cs & buf_we));
            check("oe_low_in_write", 128'(buf_oe), 128'(0));
            check("ready_low_in_write", 128'(in_ready), 128'(0));
            n_writes++;
            if (exp_addr.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write",
                         buf_address, buf_data);
            end else begin
                check("write_addr", 128'(buf_address), 128'(exp_addr.pop_front()));
                check("write_data", buf_data, exp_data.pop_front());
            end
        end
    end

    task automatic do_start(input logic [7:0] base);
        @(negedge clk);
        start      = 1'b1;
        start_addr = base;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Offer every sample in samp back-to-back; returns at the negedge after the last accept.
    task automatic push(input bit last_on_final);
        int waited;
        stalls = 0;
        for (int i = 0; i < samp.size(); i++) begin
            in_valid = 1'b1;
            in_data  = samp[i];
            in_last  = last_on_final && (i == samp.size() - 1);
            waited   = 0;
            while (!in_ready && waited < 20) begin
                stalls++;
                waited++;
                @(negedge clk);
            end
            if (!in_ready) begin
                n_checks++;
                $display("FAIL accept_timeout: actual in_ready=0 for 20 cycles required=1 (sample %0d)", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fill(input int n, input logic [15:0] first);
        samp.delete();
        for (int i = 0; i < n; i++) samp.push_back(first + 16'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        rst = 1'b1; start = 1'b0; start_addr = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_cs", 128'(buf_cs), 128'(0));
        check("rst_word_count", 128'(word_count), 128'(0));
        check("rst_err", 128'(err_overflow), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Full word
        fill(8, 16'h0001);
        plan(8'h10);
        do_start(8'h10);
        push(1'b1);
        check("t1_stalls", 128'(stalls), 128'(0));
        check("t1_cs", 128'(buf_cs), 128'(1));
        check("t1_addr", 128'(buf_address), 128'(8'h10));
        check("t1_data", buf_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("t1_done_early", 128'(frame_done), 128'(0));
        @(negedge clk);
        check("t1_done", 128'(frame_done), 128'(1));
        check("t1_addr_hold", 128'(buf_address), 128'(8'h10));
        check("t1_data_hold", buf_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        @(negedge clk);
        check("t1_done_pulse", 128'(frame_done), 128'(0));
        check("t1_idle", 128'(busy), 128'(0));
        check("t1_wc", 128'(word_count), 128'(exp_wc));
        check("t1_wc_lit", 128'(word_count), 128'(1));
        check("t1_err", 128'(err_overflow), 128'(exp_err));

        // Partial word
        samp.delete();
        samp.push_back(16'hAAAA); samp.push_back(16'hBBBB); samp.push_back(16'hCCCC);
        plan(8'h00);
        do_start(8'h00);
        push(1'b1);
        check("t2_addr", 128'(buf_address), 128'(0));
        check("t2_data", buf_data, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
        repeat (2) @(negedge clk);
        check("t2_wc", 128'(word_count), 128'(1));

        // Multi-word with backpressure
        fill(20, 16'h0100);
        plan(8'h30);
        do_start(8'h30);
        push(1'b1);
        check("t3_stalls", 128'(stalls), 128'(2));
        check("t3_addr", 128'(buf_address), 128'(8'h32));
        check("t3_data", buf_data, 128'h0000_0000_0000_0000_0113_0112_0111_0110);
        repeat (2) @(negedge clk);
        check("t3_wc", 128'(word_count), 128'(3));
        check("t3_wc_model", 128'(word_count), 128'(exp_wc));
        check("t3_err", 128'(err_overflow), 128'(0));

        // Overflow at the buffer top
        fill(24, 16'h0200);
        plan(8'hFF);
        wr0 = n_writes;
        do_start(8'hFF);
        push(1'b1);
        check("t4_stalls", 128'(stalls), 128'(1));
        check("t4_no_write", 128'(buf_cs), 128'(0));
        check("t4_done", 128'(frame_done), 128'(1));
        @(negedge clk);
        check("t4_writes", 128'(n_writes - wr0), 128'(1));
        check("t4_wc", 128'(word_count), 128'(1));
        check("t4_err", 128'(err_overflow), 128'(1));
        check("t4_err_model", 128'(err_overflow), 128'(exp_err));
        check("t4_idle", 128'(busy), 128'(0));

        // A later start clears the error
        samp.delete();
        samp.push_back(16'h1234);
        plan(8'h50);
        do_start(8'h50);
        check("t4b_err_clear", 128'(err_overflow), 128'(0));
        check("t4b_wc_clear", 128'(word_count), 128'(0));
        push(1'b1);
        repeat (2) @(negedge clk);
        check("t4b_wc", 128'(word_count), 128'(1));

        // Reset in the middle of a word
        fill(5, 16'h0300);
        do_start(8'h60);
        push(1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_ready", 128'(in_ready), 128'(0));
        check("t5_addr", 128'(buf_address), 128'(0));
        check("t5_data", buf_data, 128'(0));
        check("t5_cs", 128'(buf_cs), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; in_data = 16'hDEAD;
        repeat (4) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_idle_busy", 128'(busy), 128'(0));
        check("t5_idle_wc", 128'(word_count), 128'(0));

        // Start while busy is ignored
        fill(8, 16'h0400);
        plan(8'h20);
        samp.delete();
        for (int i = 0; i < 3; i++) samp.push_back(16'h0400 + 16'(i));
        do_start(8'h20);
        push(1'b0);
        start = 1'b1; start_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        check("t6_busy", 128'(busy), 128'(1));
        samp.delete();
        for (int i = 3; i < 8; i++) samp.push_back(16'h0400 + 16'(i));
        push(1'b1);
        check("t6_addr", 128'(buf_address), 128'(8'h20));
        check("t6_data", buf_data, 128'h0407_0406_0405_0404_0403_0402_0401_0400);
        repeat (2) @(negedge clk);
        check("t6_wc", 128'(word_count), 128'(1));

        repeat (3) @(negedge clk);
        check("pending_writes", 128'(exp_addr.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
